// File: rtl/disp_pkg.sv
// Shared types and constants for the seven-segment scan driver.
package disp_pkg;

   typedef logic [6:0] seg_t;

   // Active-low segment pattern with every segment dark.
   localparam seg_t SEG_OFF = 7'b1111111;

   // Active-low gfedcba patterns for hex digits 0..F.
   localparam seg_t HEX_SEG_TABLE [0:15] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000,  // 9
      7'b0001000,  // A
      7'b0000011,  // b
      7'b1000110,  // C
      7'b0100001,  // d
      7'b0000110,  // E
      7'b0001110   // F
   };

endpackage

// File: rtl/display.sv
// Combinational hex-nibble to active-low seven-segment decoder.
module display
   import disp_pkg::*;
(
   input  logic [3:0] s,
   output logic [6:0] seg
);

   assign seg = HEX_SEG_TABLE[s];

endmodule

// File: rtl/display_scan_n.sv
// Time-multiplexed driver for NUM_DIGITS common-anode seven-segment digits with
// per-slot blanking, frame-atomic data update, digit masking and leading-zero blanking.
module display_scan_n
   import disp_pkg::*;
#(
   parameter int unsigned NUM_DIGITS  = 2,
   parameter int unsigned DIV_COUNT   = 4800,
   parameter int unsigned BLANK_COUNT = 240
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] data,
   input  logic [NUM_DIGITS-1:0]   digit_mask,
   input  logic                    lz_blank,
   output logic [6:0]              seg,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    frame_done
);

   localparam int unsigned SW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
   localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

   localparam logic [SW-1:0] SLOT_LAST  = SW'(DIV_COUNT - 1);
   localparam logic [SW-1:0] SLOT_BLANK = SW'(BLANK_COUNT);
   localparam logic [DW-1:0] DIG_LAST   = DW'(NUM_DIGITS - 1);

   if (BLANK_COUNT >= DIV_COUNT || NUM_DIGITS < 1 || DIV_COUNT < 2) begin : g_param_check
      $error("display_scan_n: need NUM_DIGITS >= 1, DIV_COUNT >= 2, BLANK_COUNT < DIV_COUNT");
   end

   logic [SW-1:0]           r_slot_cnt;
   logic [DW-1:0]           r_digit_idx;
   logic [4*NUM_DIGITS-1:0] r_shadow;
   logic [4*NUM_DIGITS-1:0] r_active;
   logic [6:0]              r_seg;
   logic [NUM_DIGITS-1:0]   r_an;
   logic                    r_frame_done;

   logic                    w_frame_end;
   logic                    w_zero_above;
   logic [NUM_DIGITS-1:0]   w_lz;
   logic [3:0]              w_nib;
   logic                    w_sel_on;
   logic [NUM_DIGITS-1:0]   w_an_sel;
   logic [6:0]              w_dec_seg;
   logic [6:0]              w_seg_d;
   logic [NUM_DIGITS-1:0]   w_an_d;

   assign w_frame_end = (r_slot_cnt == SLOT_LAST) && (r_digit_idx == DIG_LAST);

   // Slot counter wraps every DIV_COUNT cycles and then advances the scanned digit.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_slot_cnt  <= '0;
         r_digit_idx <= '0;
      end else if (r_slot_cnt == SLOT_LAST) begin
         r_slot_cnt  <= '0;
         r_digit_idx <= (r_digit_idx == DIG_LAST) ? '0 : r_digit_idx + 1'b1;
      end else begin
         r_slot_cnt  <= r_slot_cnt + 1'b1;
      end
   end

   // Shadow takes every load; active is only refreshed at the frame boundary so a frame never
   // tears. A load in the boundary cycle itself bypasses the shadow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_shadow <= '0;
         r_active <= '0;
      end else begin
         if (load) begin
            r_shadow <= data;
         end
         if (w_frame_end) begin
            r_active <= load ? data : r_shadow;
         end
      end
   end

   // A digit is a leading zero when it and every more significant nibble are zero; digit 0
   // always stays visible so a zero value still shows one "0".
   always_comb begin
      w_zero_above = 1'b1;
      w_lz         = '0;
      for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
         w_zero_above = w_zero_above & (r_active[4*i +: 4] == 4'h0);
         w_lz[i]      = lz_blank & w_zero_above;
      end
      w_lz[0] = 1'b0;
   end

   // Select the nibble, lit condition and anode pattern of the digit being scanned.
   always_comb begin
      w_nib    = 4'h0;
      w_sel_on = 1'b0;
      w_an_sel = '1;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (r_digit_idx == DW'(i)) begin
            w_nib       = r_active[4*i +: 4];
            w_sel_on    = digit_mask[i] & ~w_lz[i];
            w_an_sel[i] = 1'b0;
         end
      end
   end

   display u_display (
      .s   (w_nib),
      .seg (w_dec_seg)
   );

   // Dark during the anti-ghosting window and for masked or blanked digits.
   always_comb begin
      w_seg_d = SEG_OFF;
      w_an_d  = '1;
      if ((r_slot_cnt >= SLOT_BLANK) && w_sel_on) begin
         w_seg_d = w_dec_seg;
         w_an_d  = w_an_sel;
      end
   end

   // Registered pin drivers; they trail the counter state by one clock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_seg        <= SEG_OFF;
         r_an         <= '1;
         r_frame_done <= 1'b0;
      end else begin
         r_seg        <= w_seg_d;
         r_an         <= w_an_d;
         r_frame_done <= w_frame_end;
      end
   end

   assign seg        = r_seg;
   assign an         = r_an;
   assign frame_done = r_frame_done;

endmodule

// File: tb/tb_display_scan_n.sv
// Randomized and directed bench for display_scan_n (4 digits, 8-cycle slots, 2-cycle blanking)
// against a cycle-count based reference model.
module tb_display_scan_n;

   localparam int ND  = 4;
   localparam int DIV = 8;
   localparam int BLK = 2;
   localparam int FRAME = ND * DIV;

   logic        clk = 1'b0;
   logic        reset;
   logic        load;
   logic [15:0] data;
   logic [3:0]  digit_mask;
   logic        lz_blank;
   logic [6:0]  seg;
   logic [3:0]  an;
   logic        frame_done;

   int total = 0;
   int bad   = 0;

   // Reference model state: cycles since reset release plus the two data registers.
   int unsigned m_t;
   logic [15:0] m_shadow;
   logic [15:0] m_active;
   logic [6:0]  e_seg;
   logic [3:0]  e_an;
   logic        e_fd;

   display_scan_n #(
      .NUM_DIGITS  (ND),
      .DIV_COUNT   (DIV),
      .BLANK_COUNT (BLK)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .data       (data),
      .digit_mask (digit_mask),
      .lz_blank   (lz_blank),
      .seg        (seg),
      .an         (an),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [6:0] hex7(input logic [3:0] v);
      case (v)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   task automatic model_reset();
      m_t      = 0;
      m_shadow = '0;
      m_active = '0;
   endtask

   // Called at each rising edge: predicts the pins after this edge, then advances the model.
   task automatic model_edge();
      int unsigned slot;
      int unsigned idx;
      logic [15:0] upper;
      logic        lzd;
      logic        boundary;
      slot     = m_t % DIV;
      idx      = (m_t / DIV) % ND;
      boundary = (m_t % FRAME) == FRAME - 1;
      upper    = m_active >> (4 * idx);
      lzd      = lz_blank && (idx != 0) && (upper == 16'h0);
      if (slot < BLK || !digit_mask[idx] || lzd) begin
         e_seg = 7'h7F;
         e_an  = 4'hF;
      end else begin
         e_seg = hex7(upper[3:0]);
         e_an  = ~(4'b0001 << idx);
      end
      e_fd = boundary;
      if (boundary) m_active = load ? data : m_shadow;
      if (load) m_shadow = data;
      m_t++;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("seg", seg, e_seg);
      check("an", an, e_an);
      check("frame_done", frame_done, e_fd);
      check("an_onecold", ($countones(~an) <= 1), 1);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic load_once(input logic [15:0] v);
      load = 1'b1;
      data = v;
      tick();
      load = 1'b0;
   endtask

   // Leaves the model sitting on the frame-boundary state, ready for the next edge.
   task automatic run_to_boundary();
      for (int i = 0; i < FRAME && (m_t % FRAME) != FRAME - 1; i++) tick();
   endtask

   initial begin
      reset      = 1'b1;
      load       = 1'b0;
      data       = '0;
      digit_mask = 4'hF;
      lz_blank   = 1'b0;
      model_reset();
      #2;
      check("rst_seg", seg, 7'h7F);
      check("rst_an", an, 4'hF);
      check("rst_fd", frame_done, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Scenario 1: first load only shows after the first frame boundary.
      load_once(16'h1234);
      run(2 * FRAME);

      // Scenario 2: two loads mid-frame, the later one wins at the next boundary.
      while ((m_t % FRAME) != 10) tick();
      load_once(16'hABCD);
      tick();
      load_once(16'h5678);
      run(2 * FRAME);

      // Scenario 3: load exactly on the boundary cycle takes the bypass path.
      run_to_boundary();
      load_once(16'h9999);
      run(FRAME);

      // Scenario 4: leading-zero blanking.
      lz_blank = 1'b1;
      load_once(16'h0070);
      run_to_boundary();
      run(FRAME + 1);
      load_once(16'h0000);
      run(2 * FRAME);
      lz_blank = 1'b0;

      // Scenario 5: sparse digit mask.
      digit_mask = 4'b1010;
      load_once(16'h8888);
      run(2 * FRAME);
      digit_mask = 4'hF;

      // Scenario 6: asynchronous reset while digit 2 is lit.
      load_once(16'h1234);
      run_to_boundary();
      tick();
      while ((m_t % FRAME) != 2 * DIV + 5) tick();
      check("pre_rst_an", an, 4'b1011);
      #2 reset = 1'b1;
      #1;
      check("async_rst_seg", seg, 7'h7F);
      check("async_rst_an", an, 4'hF);
      check("async_rst_fd", frame_done, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      run(FRAME + 8);

      // Randomized traffic, biased toward zero-heavy values to exercise blanking.
      for (int i = 0; i < 800; i++) begin
         logic [15:0] keep;
         case ($urandom_range(0, 3))
            0:       keep = 16'hFFFF;
            1:       keep = 16'h00FF;
            2:       keep = 16'h000F;
            default: keep = 16'h0000;
         endcase
         data       = 16'($urandom) & keep;
         load       = ($urandom_range(0, 5) == 0);
         lz_blank   = 1'($urandom);
         if ($urandom_range(0, 15) == 0) digit_mask = 4'($urandom);
         tick();
      end
      load = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
